load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Initiator side of the on-chip memory port: accepts one load/store request at a time from the core and drives the memory's word address, read strobe, byte-lane write mask and write data.
- Aligns and replicates store data into byte lanes; extracts, sign-extends or zero-extends load data.
- Flags misaligned or illegal requests without touching memory.
- Sits between the core's execute stage and the synchronous-read block memory.

Parameters:
MEM_LATENCY, 1, cycles from the mem_read cycle until mem_read_data is valid (range 1..4)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_write  input  1  1 = store, 0 = load
req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load result (0 for stores and errors)
resp_error  output  1  misaligned or illegal size, qualified by resp_valid
mem_addr  output  32  word-aligned address, bits [1:0] always 0
mem_read  output  1  read strobe
mem_read_data  input  32  registered memory output
mem_write_mask  output  4  byte-lane write enables
mem_write_data  output  32  lane-replicated store data

Behaviour:
- Reset (asynchronous, active-high): state = IDLE. req_ready=1. resp_valid=0, resp_rdata=0, resp_error=0, mem_read=0, mem_write_mask=0, mem_addr=0, mem_write_data=0. If rst asserts mid-operation, the transaction is abandoned, no response is produced and memory strobes drop immediately.
- States: IDLE, ISSUE, WAIT, RESP.
- req_ready=1 only in IDLE. The handshake completes on a rising edge with req_valid && req_ready. All request fields are captured into registers on that edge.
- Alignment check at accept:
  - half requires addr[0]=0.
  - word requires addr[1:0]=0.
  - size 3 is always an error.
  - On error: go directly to RESP with resp_error=1 and resp_rdata=0. No memory strobe is issued.
- ISSUE (exactly 1 cycle):
  - mem_addr = {addr[31:2],2'b00}.
  - Load: mem_read=1, mask=0. Next state is WAIT, with the latency counter loaded with MEM_LATENCY-1.
  - Store: mem_read=0, and mask/data as below. Next state is RESP.
- Store lanes, with o = addr[1:0]:
  - byte: data={4{wdata[7:0]}}, mask=4'b0001<<o.
  - half: data={2{wdata[15:0]}}, mask=4'b0011<<o.
  - word: data=wdata, mask=4'b1111.
- WAIT:
  - Counter decrements each cycle.
  - When the counter is 0, sample mem_read_data, shift it right by 8*o, extend per size/unsigned into resp_rdata, and go to RESP.
  - With MEM_LATENCY=1, WAIT lasts 1 cycle.
- RESP (1 cycle): resp_valid=1, then return to IDLE. The response outputs hold their values until the next response. There is no response backpressure; the consumer must sample on the pulse.
- Latency, measured in cycles from the accept edge to the resp_valid cycle:
  - Store: 2.
  - Load: 2+MEM_LATENCY.
  - Error: 1.
  - Back-to-back issue is possible: req_ready returns in the cycle after RESP.
- Outside ISSUE, mem_read=0 and mem_write_mask=0. mem_addr and mem_write_data hold their last values.
- req_* fields may change freely while req_ready=0 and are ignored.

Decomposition:
- Shared package lsu_pkg holds:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD constants.
  - The state encoding (IDLE, ISSUE, WAIT, RESP).
  - A misalignment predicate function.
- One natural combinational sub-module, lsu_align, holding store lane replication/mask generation and load extraction/extension. It can be unit-tested exhaustively over offset, size and unsigned.

Test Plan:
- Word store addr 0x10, wdata 0xDEADBEEF -> one ISSUE cycle with mem_addr 0x10, mask 4'b1111, data 0xDEADBEEF; resp_valid 2 cycles after accept, resp_error=0; a following word load of 0x10 returns 0xDEADBEEF 3 cycles after accept.
- Byte store 0x80 to addr 0x13, then signed byte load 0x13 -> store mask 4'b1000, data 0x80808080; load resp_rdata 0xFFFFFF80; unsigned load returns 0x00000080.
- Half store 0xBEEF to addr 0x22, then signed half load 0x22 -> mask 4'b1100; load returns 0xFFFFBEEF; unsigned load returns 0x0000BEEF; bytes at 0x20/0x21 are unchanged.
- Half load addr 0x21, word store addr 0x12, size 3 -> each gives resp_error=1 and resp_rdata=0 one cycle after accept; mem_read and mem_write_mask stay 0 throughout.
- rst asserted during WAIT of a load -> outputs go to reset values immediately; no resp_valid pulse appears; req_ready=1 after release, and the next request completes normally.
- MEM_LATENCY=3 with a delayed memory model, two back-to-back loads -> each resp_valid arrives 5 cycles after its accept, with correct data; req_ready is low for the 5 cycles following each accept edge and high again in the cycle after RESP.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM encoding
// and the alignment predicate used when a request is accepted.
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [1:0] SIZE_BAD  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } lsu_state_t;

    // True when the request must be rejected without touching memory:
    // halves need an even address, words need a word-aligned address,
    // and size 3 is never legal.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] offset);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = offset[0];
            SIZE_WORD: bad = (offset != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit. Purely combinational:
// store data is replicated across lanes with a matching write mask, and
// load data is shifted down to bit 0 and sign- or zero-extended.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] store_data,
    output logic [3:0]  store_mask,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    // Load data moved down so the addressed byte sits in bits [7:0].
    assign shifted = rdata >> {offset, 3'b000};

    // Store lanes: replicate the low byte/half into every lane and enable
    // only the lanes covered by the access.
    always_comb begin
        store_data = wdata;
        store_mask = 4'b0000;
        case (size)
            SIZE_BYTE: begin
                store_data = {4{wdata[7:0]}};
                store_mask = 4'b0001 << offset;
            end
            SIZE_HALF: begin
                store_data = {2{wdata[15:0]}};
                store_mask = 4'b0011 << offset;
            end
            SIZE_WORD: begin
                store_data = wdata;
                store_mask = 4'b1111;
            end
            default: begin
                store_data = wdata;
                store_mask = 4'b0000;
            end
        endcase
    end

    // Load extension: the top bits copy the sign bit unless zero-extension
    // is requested.
    always_comb begin
        load_data = rdata;
        case (size)
            SIZE_BYTE: load_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
            SIZE_HALF: load_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            default:   load_data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time from the core, issues a
// single memory strobe cycle, waits out the memory read latency for loads
// and reports completion with a one-cycle resp_valid pulse.
//
// Handshake: a request is taken on the rising edge where req_valid and
// req_ready are both 1; req_ready is 1 only while idle, and request fields
// are ignored at all other times. resp_valid is a single-cycle pulse with
// no backpressure; resp_rdata/resp_error hold until the next response.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_LATENCY = 1
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    input  logic [31:0] mem_read_data,
    output logic [3:0]  mem_write_mask,
    output logic [31:0] mem_write_data
);

    // Counter reload value: WAIT lasts MEM_LATENCY cycles, ending at zero.
    localparam logic [1:0] LAT_LOAD = 2'(MEM_LATENCY - 1);

    lsu_state_t  state;
    lsu_state_t  state_next;

    logic        write_q;
    logic        unsigned_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [1:0]  lat_cnt;
    logic [31:0] addr_hold;
    logic [31:0] wdata_hold;

    logic        accept;
    logic        req_bad;
    logic        wait_done;

    logic [31:0] store_data;
    logic [3:0]  store_mask;
    logic [31:0] load_data;

    assign accept    = req_valid && (state == S_IDLE);
    assign req_bad   = is_misaligned(req_size, req_addr[1:0]);
    assign wait_done = (state == S_WAIT) && (lat_cnt == 2'd0);

    lsu_align u_align (
        .size        (size_q),
        .offset      (addr_q[1:0]),
        .is_unsigned (unsigned_q),
        .wdata       (wdata_q),
        .rdata       (mem_read_data),
        .store_data  (store_data),
        .store_mask  (store_mask),
        .load_data   (load_data)
    );

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and the state-decoded outputs. Strobes are live only in
    // ISSUE; address and write data otherwise show the last issued values.
    always_comb begin
        state_next     = state;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        mem_read       = 1'b0;
        mem_write_mask = 4'b0000;
        mem_addr       = addr_hold;
        mem_write_data = wdata_hold;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = req_bad ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_addr = {addr_q[31:2], 2'b00};
                if (write_q) begin
                    mem_write_mask = store_mask;
                    mem_write_data = store_data;
                    state_next     = S_RESP;
                end else begin
                    mem_read   = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lat_cnt == 2'd0) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Capture the request fields on the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            size_q     <= SIZE_BYTE;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
        end else if (accept) begin
            write_q    <= req_write;
            unsigned_q <= req_unsigned;
            size_q     <= req_size;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
        end
    end

    // Read latency counter: loaded on leaving ISSUE for a load, counts to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cnt <= 2'd0;
        end else if (state == S_ISSUE) begin
            lat_cnt <= LAT_LOAD;
        end else if (state == S_WAIT && lat_cnt != 2'd0) begin
            lat_cnt <= lat_cnt - 2'd1;
        end
    end

    // Remember the last issued address and store data so the memory port
    // holds them steady between transactions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_hold  <= 32'd0;
            wdata_hold <= 32'd0;
        end else if (state == S_ISSUE) begin
            addr_hold <= {addr_q[31:2], 2'b00};
            if (write_q) begin
                wdata_hold <= store_data;
            end
        end
    end

    // Response payload, loaded when the outcome is known and held after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_rdata <= 32'd0;
            resp_error <= 1'b0;
        end else if (accept && req_bad) begin
            resp_rdata <= 32'd0;
            resp_error <= 1'b1;
        end else if (state == S_ISSUE && write_q) begin
            resp_rdata <= 32'd0;
            resp_error <= 1'b0;
        end else if (wait_done) begin
            resp_rdata <= load_data;
            resp_error <= 1'b0;
        end
    end

endmodule
